temp_disp_fmt: RTL and testbench

Converts a raw DS18B20 temperature word into the 24-bit, six-digit packed code consumed by the six-digit seven-segment scan driver. It sits between the 1-Wire temperature reader and the display driver and produces the driver's `dis_data` word. Conversion is a sequential 21-iteration double-dabble with a start/busy/done handshake.

---
 rtl/temp_disp_fmt.sv | 117 +++++++++++
 tb/tb_temp_disp_fmt.sv | 138 +++++++++++++
 2 files changed

// File: rtl/temp_disp_fmt.sv
// Formats a DS18B20 temperature word into six packed display codes for the
// seven-segment scan driver, using a sequential double-dabble conversion.
module temp_disp_fmt #(
  parameter int N_BITS = 21,
  parameter int N_BCD  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        temp_vld,
  input  logic [15:0] temp_raw,
  output logic        busy,
  output logic        dis_vld,
  output logic [23:0] dis_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST_ITER = 5'(N_BITS - 1);
  localparam int         BCD_W     = 4 * N_BCD;

  state_t state, state_next;

  logic [10:0]        raw;
  logic               neg;
  logic               err;
  logic [N_BITS-1:0]  bin;
  logic [BCD_W-1:0]   bcd;
  logic [4:0]         cnt;

  logic [10:0]             mag;
  logic [N_BITS-1:0]       n_val;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+N_BITS-1:0] shifted;
  logic [3:0]              sign_code;
  logic [23:0]             fmt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (temp_vld) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the low 11 bits of the magnitude reach the display; the 11-bit
  // negation equals the low bits of the 16-bit wrapped negation.
  always_comb begin
    mag   = neg ? (~raw + 11'd1) : raw;
    n_val = N_BITS'(mag[10:4]) * N_BITS'(10000) + N_BITS'(mag[3:0]) * N_BITS'(625);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < N_BCD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  // Leftmost code: minus, hundreds digit one, or plus. F4 is truncated.
  always_comb begin
    if (neg)                         sign_code = 4'hB;
    else if (bcd[BCD_W-1 -: 4] == 4'd1) sign_code = 4'h1;
    else                             sign_code = 4'hA;
    fmt_data = err ? 24'hFFFFFF : {sign_code, bcd[23:4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw      <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      dis_vld  <= 1'b0;
      dis_data <= 24'hFFFFFF;
    end else begin
      dis_vld <= 1'b0;
      busy    <= (state != IDLE) || (state_next != IDLE);
      case (state)
        IDLE: begin
          if (temp_vld) begin
            raw <= temp_raw[10:0];
            neg <= temp_raw[15];
            err <= !((temp_raw[15:11] == 5'h00) || (temp_raw[15:11] == 5'h1F));
          end
        end
        LOAD: begin
          bin <= n_val;
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          bcd <= shifted[BCD_W+N_BITS-1:N_BITS];
          bin <= shifted[N_BITS-1:0];
          if (cnt != LAST_ITER) cnt <= cnt + 5'd1;
        end
        DONE: begin
          dis_data <= fmt_data;
          dis_vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_disp_fmt.sv
// Scoreboard bench for temp_disp_fmt: stimulus pushes expected words with their
// due cycle; a negedge monitor checks dis_vld timing, dis_data and busy.
module tb_temp_disp_fmt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        temp_vld = 1'b0;
  logic [15:0] temp_raw = '0;
  logic        busy;
  logic        dis_vld;
  logic [23:0] dis_data;

  temp_disp_fmt dut (
    .clk(clk), .rst_n(rst_n), .temp_vld(temp_vld), .temp_raw(temp_raw),
    .busy(busy), .dis_vld(dis_vld), .dis_data(dis_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] data; int due; } exp_t;
  exp_t        sb[$];
  int          last_acc = -1000;
  logic [23:0] cur_exp = 24'hFFFFFF;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference: temperature in ten-thousandths of a degree, split into decimal digits.
  function automatic logic [23:0] ref_fmt(input logic [15:0] r);
    int mag, ip, fp, n;
    logic [3:0] sc;
    if (!((r[15:11] == 5'h00) || (r[15:11] == 5'h1F))) return 24'hFFFFFF;
    mag = r[15] ? 65536 - int'(r) : int'(r);
    ip  = (mag / 16) % 128;
    fp  = mag % 16;
    n   = ip * 10000 + fp * 625;
    sc  = r[15] ? 4'hB : (((n / 1000000) == 1) ? 4'h1 : 4'hA);
    return {sc, 4'((n / 100000) % 10), 4'((n / 10000) % 10), 4'((n / 1000) % 10),
            4'((n / 100) % 10), 4'((n / 10) % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic exp_vld;
    exp_t e;
    checkOutput("busy", 32'(busy), 32'(rst_n && (cyc >= last_acc) && (cyc <= last_acc + 23)));
    exp_vld = (sb.size() > 0) && (sb[0].due == cyc);
    checkOutput("dis_vld", 32'(dis_vld), 32'(exp_vld));
    if (exp_vld) begin
      e = sb.pop_front();
      cur_exp = e.data;
      checkOutput("dis_data", 32'(dis_data), 32'(e.data));
    end else begin
      checkOutput("hold", 32'(dis_data), 32'(cur_exp));
    end
  end

  task automatic applyStimulus(input logic [15:0] raw, input int gap);
    int k;
    repeat (gap) @(posedge clk);
    #1;
    temp_vld = 1'b1;
    temp_raw = raw;
    @(posedge clk);
    #1;
    temp_vld = 1'b0;
    temp_raw = 16'($urandom);
    k = cyc;
    if (k - last_acc >= 24) begin
      last_acc = k;
      sb.push_back('{ref_fmt(raw), k + 23});
    end
  endtask

  initial begin
    logic [15:0] r;
    int wait_cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    applyStimulus(16'h0191, 2);
    applyStimulus(16'hFC90, 30);
    applyStimulus(16'h07D0, 30);
    applyStimulus(16'hFFFF, 30);
    applyStimulus(16'h0000, 30);
    applyStimulus(16'h0800, 30);
    applyStimulus(16'h07FF, 30);
    applyStimulus(16'hF800, 30);

    // Second pulses at 5, 20, 23 cycles dropped; 24 accepted.
    applyStimulus(16'h0191, 30);
    applyStimulus(16'hFC90, 4);
    applyStimulus(16'h07D0, 14);
    applyStimulus(16'hFFFF, 2);
    applyStimulus(16'h07FF, 0);

    // Reset ten cycles into a conversion.
    applyStimulus(16'h0123, 30);
    repeat (9) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    sb.delete();
    last_acc = -1000;
    cur_exp  = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(16'h0191, 2);

    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r[15:11] = {5{r[15]}};
      applyStimulus(r, $urandom_range(0, 35));
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 100) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    checkOutput("drain", 32'(sb.size()), 32'd0);
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
